// File: rtl/mem_xbar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_xbar_pkg
//  Description : Shared FSM encoding and sizing helpers for mem_xbar_n.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_xbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ERR_RSP = 2'd2
    } state_e;

    localparam int ERR_CNT_W = 16;

    // Select-index width for a given slave count; a single slave still needs one bit.
    function automatic int sel_w(input int n_slv);
        return (n_slv > 1) ? $clog2(n_slv) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_xbar_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_xbar_n_if
//  Description : Master-side request/response and slave-side bus bundle.
//                Optional log outputs appear under MEM_XBAR_ERR_LOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_xbar_n_if #(
    parameter int N_SLV  = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic                      i_req;
    logic [ADDR_W-1:0]         i_addr;
    logic [DATA_W-1:0]         i_data;
    logic [DATA_W/8-1:0]       i_mask;
    logic                      i_wren;
    logic                      o_ready;
    logic                      o_rvalid;
    logic [DATA_W-1:0]         o_rdata;
    logic                      o_err;
    logic [N_SLV-1:0]          o_slv_req;
    logic [ADDR_W-1:0]         o_slv_addr;
    logic [DATA_W-1:0]         o_slv_data;
    logic [DATA_W/8-1:0]       o_slv_mask;
    logic                      o_slv_wren;
    logic [N_SLV-1:0]          i_slv_ready;
    logic [N_SLV-1:0]          i_slv_rvalid;
    logic [N_SLV*DATA_W-1:0]   i_slv_rdata;
`ifdef MEM_XBAR_ERR_LOG_EN
    logic [ADDR_W-1:0]                  o_err_addr;
    logic [mem_xbar_pkg::ERR_CNT_W-1:0] o_err_cnt;
`endif

    // master: the surrounding core and slave devices; slave: the crossbar itself
    modport master (
        output i_req, i_addr, i_data, i_mask, i_wren,
        output i_slv_ready, i_slv_rvalid, i_slv_rdata,
        input  o_ready, o_rvalid, o_rdata, o_err,
        input  o_slv_req, o_slv_addr, o_slv_data, o_slv_mask, o_slv_wren
`ifdef MEM_XBAR_ERR_LOG_EN
        , input o_err_addr, o_err_cnt
`endif
    );

    modport slave (
        input  i_req, i_addr, i_data, i_mask, i_wren,
        input  i_slv_ready, i_slv_rvalid, i_slv_rdata,
        output o_ready, o_rvalid, o_rdata, o_err,
        output o_slv_req, o_slv_addr, o_slv_data, o_slv_mask, o_slv_wren
`ifdef MEM_XBAR_ERR_LOG_EN
        , output o_err_addr, o_err_cnt
`endif
    );
endinterface
`default_nettype wire

// File: rtl/mem_xbar_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mem_xbar_decode
//  Description : Combinational region decoder; lowest matching index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_xbar_decode #(
    parameter int N_SLV  = 4,
    parameter int ADDR_W = 30,
    parameter int SEL_W  = 2
) (
    input  wire logic [ADDR_W-1:0]       addr_i,
    input  wire logic [N_SLV*ADDR_W-1:0] region_start_i,
    input  wire logic [N_SLV*ADDR_W-1:0] region_limit_i,
    output logic      [SEL_W-1:0]        sel_o,
    output logic                         miss_o
);
    // Scan from the top so that the lowest hitting index is the last one written.
    always_comb begin
        sel_o  = '0;
        miss_o = 1'b1;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr_i >= region_start_i[i*ADDR_W +: ADDR_W]) &&
                (addr_i <= region_limit_i[i*ADDR_W +: ADDR_W])) begin
                sel_o  = SEL_W'(i);
                miss_o = 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mem_xbar_n.sv
`default_nettype none
// ============================================================================
//  Module      : mem_xbar_n
//  Description : One-master to N-slave address-decoded crossbar, one
//                outstanding read. Optional miss log: MEM_XBAR_ERR_LOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_xbar_n
    import mem_xbar_pkg::*;
#(
    parameter int                      N_SLV        = 4,
    parameter int                      ADDR_W       = 30,
    parameter int                      DATA_W       = 32,
    parameter logic [N_SLV*ADDR_W-1:0] REGION_START = {(N_SLV*ADDR_W){1'b0}},
    parameter logic [N_SLV*ADDR_W-1:0] REGION_LIMIT = {(N_SLV*ADDR_W){1'b0}}
) (
    input wire logic   clk,
    input wire logic   rst,
    mem_xbar_n_if.slave bus
);
    localparam int SEL_W = sel_w(N_SLV);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [SEL_W-1:0]    w_sel;
    logic                w_miss;
    logic                w_ready;
    logic [N_SLV-1:0]    w_onehot;

    mem_xbar_decode #(
        .N_SLV  (N_SLV),
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W)
    ) u_decode (
        .addr_i         (bus.i_addr),
        .region_start_i (REGION_START),
        .region_limit_i (REGION_LIMIT),
        .sel_o          (w_sel),
        .miss_o         (w_miss)
    );

    always_comb begin
        for (int i = 0; i < N_SLV; i++) begin
            w_onehot[i] = (w_sel == SEL_W'(i));
        end
    end

    assign bus.o_slv_addr = bus.i_addr;
    assign bus.o_slv_data = bus.i_data;
    assign bus.o_slv_mask = bus.i_mask;
    assign bus.o_slv_wren = bus.i_wren;
    assign bus.o_rvalid   = rvalid_q;
    assign bus.o_rdata    = rdata_q;
    assign bus.o_err      = err_q;
    assign bus.o_ready    = w_ready;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        rvalid_d      = 1'b0;
        err_d         = 1'b0;
        rdata_d       = rdata_q;
        w_ready       = 1'b0;
        bus.o_slv_req = '0;
        case (state_q)
            ST_IDLE: begin
                // Unmapped requests are always taken so the error can be returned.
                w_ready       = w_miss ? 1'b1 : bus.i_slv_ready[w_sel];
                bus.o_slv_req = w_onehot & {N_SLV{bus.i_req && !w_miss}};
                if (bus.i_req && w_ready) begin
                    if (bus.i_wren) begin
                        err_d = w_miss;
                    end else if (w_miss) begin
                        state_d = ST_ERR_RSP;
                    end else begin
                        sel_d   = w_sel;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (bus.i_slv_rvalid[sel_q]) begin
                    rdata_d  = bus.i_slv_rdata[int'(sel_q)*DATA_W +: DATA_W];
                    rvalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_ERR_RSP: begin
                rdata_d  = '0;
                rvalid_d = 1'b1;
                err_d    = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef MEM_XBAR_ERR_LOG_EN
    logic [ADDR_W-1:0]    err_addr_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 w_log;

    assign w_log          = (state_q == ST_IDLE) && bus.i_req && w_miss;
    assign bus.o_err_addr = err_addr_q;
    assign bus.o_err_cnt  = err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (w_log) begin
            err_addr_q <= bus.i_addr;
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + 1'b1;
            end
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_mem_xbar_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_xbar_n
//  Description : Self-checking bench for mem_xbar_n against a region-table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_xbar_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_xbar_n_if #(.N_SLV(4), .ADDR_W(30), .DATA_W(32)) bus  ();
    mem_xbar_n_if #(.N_SLV(4), .ADDR_W(30), .DATA_W(32)) bus2 ();

    mem_xbar_n #(
        .N_SLV(4), .ADDR_W(30), .DATA_W(32),
        .REGION_START({30'h300, 30'h200, 30'h100, 30'h000}),
        .REGION_LIMIT({30'h3FF, 30'h2FF, 30'h1FF, 30'h0FF})
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    // Overlapping regions 0/1; regions 2/3 are empty (start above limit).
    mem_xbar_n #(
        .N_SLV(4), .ADDR_W(30), .DATA_W(32),
        .REGION_START({30'h3FFFFFFF, 30'h3FFFFFFF, 30'h100, 30'h000}),
        .REGION_LIMIT({30'h0, 30'h0, 30'h1FF, 30'h1FF})
    ) dut_ov (.clk(clk), .rst(rst), .bus(bus2));

    int          rs [4] = '{'h000, 'h100, 'h200, 'h300};
    int          rl [4] = '{'h0FF, 'h1FF, 'h2FF, 'h3FF};
    logic [31:0] last_rdata = '0;
    logic [29:0] exp_eaddr  = '0;
    logic [15:0] exp_ecnt   = '0;

    function automatic int ref_decode(input logic [29:0] a);
        for (int i = 0; i < 4; i++) begin
            if (int'(a) >= rs[i] && int'(a) <= rl[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log();
`ifdef MEM_XBAR_ERR_LOG_EN
        chk("err_addr", bus.o_err_addr, exp_eaddr);
        chk("err_cnt", bus.o_err_cnt, exp_ecnt);
`endif
    endtask

    task automatic do_txn(input logic [29:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] m, input int stall, input int lat,
                          input logic [31:0] rd, input bit spur);
        int          idx;
        int          ns;
        logic [3:0]  oh;
        idx = ref_decode(a);
        oh  = (idx < 0) ? 4'b0 : (4'b1 << idx);
        ns  = (idx < 0) ? 0 : stall;
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        bus.i_data = d;
        bus.i_mask = m;
        bus.i_wren = w;
        for (int s = 0; s <= ns; s++) begin
            if (idx < 0)       bus.i_slv_ready = 4'($urandom);
            else if (s == ns)  bus.i_slv_ready = oh | 4'($urandom);
            else               bus.i_slv_ready = ~oh;
            #1;
            chk("ready", bus.o_ready, (idx < 0) || (s == ns));
            chk("slv_req", bus.o_slv_req, oh);
            if (s == ns)
                chk("bcast", {bus.o_slv_addr, bus.o_slv_data, bus.o_slv_mask, bus.o_slv_wren},
                    {a, d, m, w});
            tick();
        end
        if (idx < 0) begin
            exp_eaddr = a;
            if (exp_ecnt != 16'hFFFF) exp_ecnt = exp_ecnt + 16'd1;
        end
        bus.i_slv_ready = 4'hF;
        if (w) begin
            bus.i_req = 1'b0;
            chk("wr_rvalid", bus.o_rvalid, 1'b0);
            chk("wr_err", bus.o_err, idx < 0);
            chk("wr_rdata_hold", bus.o_rdata, last_rdata);
        end else if (idx < 0) begin
            #1;
            chk("miss_wait_ready", bus.o_ready, 1'b0);
            chk("miss_wait_rvalid", bus.o_rvalid, 1'b0);
            tick();
            bus.i_req = 1'b0;
            chk("miss_rsp", {bus.o_rvalid, bus.o_err, bus.o_rdata}, {1'b1, 1'b1, 32'h0});
            last_rdata = '0;
        end else begin
            for (int k = 1; k <= lat; k++) begin
                for (int j = 0; j < 4; j++) bus.i_slv_rdata[j*32 +: 32] = $urandom;
                bus.i_slv_rvalid = spur ? (4'($urandom) & ~oh) : 4'b0;
                if (k == lat) begin
                    bus.i_slv_rvalid = bus.i_slv_rvalid | oh;
                    bus.i_slv_rdata[idx*32 +: 32] = rd;
                end
                #1;
                chk("rdwait_ready", bus.o_ready, 1'b0);
                chk("rdwait_req", bus.o_slv_req, 4'b0);
                chk("rdwait_rvalid", bus.o_rvalid, 1'b0);
                tick();
            end
            bus.i_req        = 1'b0;
            bus.i_slv_rvalid = '0;
            chk("rd_rsp", {bus.o_rvalid, bus.o_err, bus.o_rdata}, {1'b1, 1'b0, rd});
            last_rdata = rd;
        end
        chk_log();
        bus.i_req       = 1'b0;
        bus.i_slv_ready = '0;
        tick();
        chk("idle_hold", {bus.o_rvalid, bus.o_err, bus.o_rdata}, {1'b0, 1'b0, last_rdata});
    endtask

    initial begin
        logic [29:0] ra;
        bus.i_req = 0; bus.i_addr = '0; bus.i_data = '0; bus.i_mask = '0; bus.i_wren = 0;
        bus.i_slv_ready = '0; bus.i_slv_rvalid = '0; bus.i_slv_rdata = '0;
        bus2.i_req = 0; bus2.i_addr = '0; bus2.i_data = '0; bus2.i_mask = '0; bus2.i_wren = 0;
        bus2.i_slv_ready = 4'hF; bus2.i_slv_rvalid = '0; bus2.i_slv_rdata = '0;

        #3;
        chk("rst_out", {bus.o_rvalid, bus.o_err, bus.o_rdata, bus.o_slv_req}, 96'h0);
        chk_log();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Directed plan
        do_txn(30'h105, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0, 1'b0);
        do_txn(30'h210, 1'b0, 32'h0, 4'hF, 0, 3, 32'h12345678, 1'b0);
        do_txn(30'h3FFFF000, 1'b0, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0);
        do_txn(30'h000, 1'b0, 32'h0, 4'hF, 4, 2, 32'hCAFEF00D, 1'b1);
        do_txn(30'h2FF, 1'b0, 32'h0, 4'h3, 0, 1, 32'hA5A55A5A, 1'b1);
        do_txn(30'h400, 1'b1, 32'h11223344, 4'h1, 0, 1, 32'h0, 1'b0);

        // Reset while a read is outstanding
        bus.i_req = 1'b1; bus.i_addr = 30'h020; bus.i_wren = 1'b0; bus.i_slv_ready = 4'b0001;
        tick();
        bus.i_req = 1'b0; bus.i_slv_ready = '0;
        tick();
        rst = 1'b1;
        #2;
        chk("midrst_out", {bus.o_rvalid, bus.o_err, bus.o_rdata, bus.o_slv_req}, 96'h0);
        rst = 1'b0;
        last_rdata = '0; exp_eaddr = '0; exp_ecnt = '0;
        bus.i_slv_rvalid = 4'b0001; bus.i_slv_rdata = {4{32'hBADBAD00}};
        tick();
        tick();
        chk("midrst_late_rvalid", {bus.o_rvalid, bus.o_rdata}, 33'h0);
        chk_log();
        bus.i_slv_rvalid = '0;
        do_txn(30'h020, 1'b0, 32'h0, 4'hF, 0, 1, 32'h0BADCAFE, 1'b0);

        // Overlap priority on the second instance (combinational only)
        bus2.i_req = 1'b1; bus2.i_addr = 30'h150;
        #1; chk("ov_150", bus2.o_slv_req, 4'b0001);
        bus2.i_addr = 30'h050;
        #1; chk("ov_050", bus2.o_slv_req, 4'b0001);
        bus2.i_addr = 30'h250;
        #1; chk("ov_miss", {bus2.o_slv_req, bus2.o_ready}, {4'b0, 1'b1});
        bus2.i_req = 1'b0;
        tick();

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) != 0) ra = 30'($urandom_range(0, 'h3FF));
            else                           ra = 30'($urandom) | 30'h400;
            do_txn(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), $urandom,
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/mem_xbar_n.md
Name: mem_xbar_n

Overview:
- Parametrised successor to the two-region core data crossbar.
- Routes one master port (core data side) to N address-decoded slave ports: dmem, MMIO, and future peripherals.
- Adds a valid/ready request handshake, variable-latency read responses from slaves, one outstanding read, and a decode-error response for unmapped addresses.
- Sits between the core data port and the slave memories/peripherals inside the CPU top level.

Parameters:
- N_SLV, 4, number of slave regions (1..8).
- ADDR_W, 30, word-address width.
- DATA_W, 32, data width; mask width is DATA_W/8.
- REGION_START, {N_SLV{30'h0}}, packed N_SLV*ADDR_W inclusive start word address per region; slot i is bits [i*ADDR_W +: ADDR_W].
- REGION_LIMIT, {N_SLV{30'h0}}, packed N_SLV*ADDR_W inclusive end word address per region.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous active-high reset.
- i_req  in  1  master request valid.
- i_addr  in  ADDR_W  master word address.
- i_data  in  DATA_W  master write data.
- i_mask  in  DATA_W/8  byte-enable mask.
- i_wren  in  1  1 = write, 0 = read.
- o_ready  out  1  request accepted this cycle when i_req && o_ready.
- o_rvalid  out  1  read response valid, one-cycle pulse.
- o_rdata  out  DATA_W  read response data.
- o_err  out  1  decode-error flag, qualified by o_rvalid for reads or by the accept cycle for writes.
- o_slv_req  out  N_SLV  one-hot slave request.
- o_slv_addr  out  ADDR_W  address broadcast to all slaves.
- o_slv_data  out  DATA_W  write data broadcast to all slaves.
- o_slv_mask  out  DATA_W/8  mask broadcast to all slaves.
- o_slv_wren  out  1  write enable broadcast to all slaves.
- i_slv_ready  in  N_SLV  per-slave request accept.
- i_slv_rvalid  in  N_SLV  per-slave read response valid.
- i_slv_rdata  in  N_SLV*DATA_W  packed per-slave read data.

Behaviour:
- Decode (combinational):
  - hit[i] = REGION_START[i] <= i_addr <= REGION_LIMIT[i].
  - On overlap the lowest index wins.
  - miss = no hit.
- FSM states: IDLE, RD_WAIT, ERR_RSP.
- Reset (async):
  - state = IDLE.
  - o_rvalid = 0, o_rdata = 0, o_err = 0.
  - Latched slave index = 0.
  - o_slv_req = 0.
- IDLE:
  - o_slv_req = onehot(sel) & {N_SLV{i_req && !miss}}.
  - Address, data, mask and wren are passed through combinationally.
  - o_ready = i_slv_ready[sel] on hit; o_ready = 1 on miss.
- Write hit accepted: posted; stay in IDLE; no response.
- Write miss accepted: no slave request; o_err pulses for one cycle on the following cycle; stay in IDLE.
- Read hit accepted: latch sel; go to RD_WAIT.
- Read miss accepted: go to ERR_RSP.
- RD_WAIT:
  - o_ready = 0 and o_slv_req = 0.
  - When i_slv_rvalid[latched] = 1: register o_rdata <= that slave's data; o_rvalid = 1 on the next cycle with o_err = 0; go to IDLE.
  - i_slv_rvalid from non-latched slaves is ignored.
- ERR_RSP:
  - o_ready = 0.
  - Next cycle: o_rvalid = 1, o_rdata = 0, o_err = 1; go to IDLE.
- Latency:
  - Minimum read latency is 2 cycles from accept: a slave with rvalid in the cycle after accept gives master o_rvalid 2 cycles after accept.
  - Back-to-back requests are accepted in the same cycle o_rvalid is asserted (state is IDLE then).
- o_rdata holds its last value when o_rvalid = 0.
- Reset mid-read: the outstanding read is abandoned and no response is issued; a late slave rvalid after reset is ignored because state is IDLE.
- i_req deasserted while a slave is not ready: no acceptance and no state change; the master may change its request.

Optional Feature:
- Macro: MEM_XBAR_ERR_LOG_EN.
- Defined:
  - Adds output o_err_addr (ADDR_W), which captures i_addr of the most recent decode miss.
  - Adds output o_err_cnt (16), a saturating count of decode misses, holding at 16'hFFFF.
  - Both reset to 0.
- Undefined: ports and logic are absent; error signalling is via o_err only.

Decomposition:
- Package mem_xbar_pkg:
  - FSM state encoding (IDLE = 0, RD_WAIT = 1, ERR_RSP = 2; 2-bit).
  - SEL_W = $clog2(N_SLV), with a minimum of 1.
  - ERR_CNT_W = 16.
- Sub-module mem_xbar_decode: purely combinational; inputs address and region vectors; outputs sel index and miss. It is the reusable and separately testable piece.

Test Plan:
- Regions 0: 0x000–0x0FF, 1: 0x100–0x1FF, 2: 0x200–0x2FF, 3: 0x300–0x3FF. Write to 0x105, data 0xDEADBEEF, mask 0xF, slave 1 ready -> o_slv_req = 4'b0010, o_ready = 1 same cycle, no o_rvalid, o_err = 0.
- Read 0x210; slave 2 rvalid 3 cycles after accept with 0x12345678 -> o_rvalid one cycle after slave rvalid, o_rdata = 0x12345678, o_err = 0; o_ready = 0 throughout the wait.
- Read 0x3FFFF000 (unmapped) -> no o_slv_req; 2 cycles after accept o_rvalid = 1, o_rdata = 0, o_err = 1. With MEM_XBAR_ERR_LOG_EN: o_err_addr = 0x3FFFF000, o_err_cnt = 1.
- Read 0x000 with slave 0 i_slv_ready low for 4 cycles -> o_ready = 0, state stays IDLE; accepted on cycle 5; a spurious i_slv_rvalid[3] during RD_WAIT is ignored.
- Assert rst in RD_WAIT before slave rvalid; then slave rvalid arrives -> no o_rvalid; all outputs 0; the next read completes normally.
- Overlapping regions 0: 0x000–0x1FF and 1: 0x100–0x1FF; read 0x150 -> o_slv_req = 4'b0001 (lowest index wins).
